// File: rtl/clock_pkg.sv
// Shared definitions for the BCD time keeper: digit limits, FSM encoding and
// the BCD range check used to validate time-set requests.
package clock_pkg;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  // Both nibbles must be decimal digits and the pair must not exceed max.
  function automatic logic bcd_ok(input logic [7:0] value, input logic [7:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX to 00. The carry output is combinational
// so a chain of these counters ripples a full rollover within one clock.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = MS_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic       carry
);

  logic at_max;

  assign at_max = (value == MAX);
  assign carry  = inc & at_max;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_value;
    end else if (inc) begin
      if (at_max) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour BCD time of day driven by single-cycle ticks, with a validated
// valid/ready time-set path and registered rollover pulses.
module bcd_time_keeper
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  parameter int FRAC_W        = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_enable,
  input  logic              i_tick,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [7:0]        i_load_hh,
  input  logic [7:0]        i_load_mm,
  input  logic [7:0]        i_load_ss,
  output logic [7:0]        o_hh,
  output logic [7:0]        o_mm,
  output logic [7:0]        o_ss,
  output logic [FRAC_W-1:0] o_frac,
  output logic              o_sec_pulse,
  output logic              o_min_pulse,
  output logic              o_day_pulse,
  output logic              o_load_err
);

  localparam logic [FRAC_W-1:0] FRAC_MAX = FRAC_W'(TICKS_PER_SEC - 1);

  state_t     state;
  logic [7:0] cap_hh;
  logic [7:0] cap_mm;
  logic [7:0] cap_ss;
  logic       tick_ok;
  logic       frac_wrap;
  logic       load_ok;
  logic       commit;
  logic       ss_carry;
  logic       mm_carry;
  logic       hh_carry;

  assign o_load_ready = (state == IDLE);
  assign tick_ok      = i_tick & i_enable & (state == IDLE);
  assign frac_wrap    = tick_ok & (o_frac == FRAC_MAX);
  assign load_ok      = bcd_ok(cap_hh, HH_MAX) & bcd_ok(cap_mm, MS_MAX) & bcd_ok(cap_ss, MS_MAX);
  assign commit       = (state == CHECK) & load_ok;

  bcd_mod_counter #(.MAX(MS_MAX)) u_ss (
    .clk(i_clk), .rst_n(i_rstn), .inc(frac_wrap), .load(commit),
    .load_value(cap_ss), .value(o_ss), .carry(ss_carry)
  );

  bcd_mod_counter #(.MAX(MS_MAX)) u_mm (
    .clk(i_clk), .rst_n(i_rstn), .inc(ss_carry), .load(commit),
    .load_value(cap_mm), .value(o_mm), .carry(mm_carry)
  );

  bcd_mod_counter #(.MAX(HH_MAX)) u_hh (
    .clk(i_clk), .rst_n(i_rstn), .inc(mm_carry), .load(commit),
    .load_value(cap_hh), .value(o_hh), .carry(hh_carry)
  );

  // Pausing only stops tick_ok; the sub-second count is held, not cleared.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_frac <= '0;
    end else if (commit) begin
      o_frac <= '0;
    end else if (tick_ok) begin
      o_frac <= frac_wrap ? '0 : o_frac + FRAC_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_sec_pulse <= 1'b0;
      o_min_pulse <= 1'b0;
      o_day_pulse <= 1'b0;
    end else begin
      o_sec_pulse <= frac_wrap;
      o_min_pulse <= ss_carry;
      o_day_pulse <= hh_carry;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      o_load_err <= 1'b0;
      // NOTE: the capture registers are reset too, so a request interrupted by reset
      // cannot leave stale fields that a later CHECK might commit.
      cap_hh     <= 8'h00;
      cap_mm     <= 8'h00;
      cap_ss     <= 8'h00;
    end else begin
      o_load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_load_valid) begin
            cap_hh <= i_load_hh;
            cap_mm <= i_load_mm;
            cap_ss <= i_load_ss;
            state  <= CHECK;
          end
        end
        CHECK: begin
          o_load_err <= ~load_ok;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
